// File: rtl/seq_delay_checker.sv
// seq_delay_checker: checks a ##[MIN_DLY:MAX_DLY] b with overlapping attempts.
// Define SEQ_CHK_FIRST_FAIL_EN to add the clr / ff_* first-fail capture ports.
module seq_delay_checker #(
    parameter int MIN_DLY = 2,
    parameter int MAX_DLY = 2,
    parameter int IMPLY   = 0,
    parameter int CNT_W   = 16,
    parameter int TS_W    = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   en,
    input  logic                                   a,
    input  logic                                   b,
`ifdef SEQ_CHK_FIRST_FAIL_EN
    input  logic                                   clr,
    output logic                                   ff_vld,
    output logic [TS_W-1:0]                        ff_start_ts,
    output logic [TS_W-1:0]                        ff_end_ts,
`endif
    output logic                                   pass_o,
    output logic [$clog2(MAX_DLY-MIN_DLY+2)-1:0]   pass_num,
    output logic                                   fail_o,
    output logic [1:0]                             fail_num,
    output logic [TS_W-1:0]                        fail_start_ts,
    output logic [TS_W-1:0]                        fail_end_ts,
    output logic [CNT_W-1:0]                       pass_cnt,
    output logic [CNT_W-1:0]                       fail_cnt
);

    localparam int PN_W = $clog2(MAX_DLY - MIN_DLY + 2);
    localparam int SW   = CNT_W + 6;
    localparam logic [SW-1:0] CNT_MAX = SW'({CNT_W{1'b1}});

    logic [TS_W-1:0]    ts;
    // pend[d]: an attempt started d edges before the last edge is still open
    logic [MAX_DLY-1:0] pend;
    logic [MAX_DLY-1:0] pend_nxt;
    logic [PN_W-1:0]    pn_nxt;
    logic [1:0]         fn_nxt;
    logic               expired;
    logic               imm_fail;
    logic               any_fail;
    logic [TS_W-1:0]    fs_nxt;
    logic [SW-1:0]      psum;
    logic [SW-1:0]      fsum;

    always_comb begin
        pend_nxt    = '0;
        pend_nxt[0] = en & a;
        for (int d = 1; d < MAX_DLY; d++)
            pend_nxt[d] = pend[d-1] & ~(b & (d >= MIN_DLY));
    end

    always_comb begin
        pn_nxt = '0;
        for (int d = 1; d <= MAX_DLY; d++)
            if (pend[d-1] && b && d >= MIN_DLY)
                pn_nxt = pn_nxt + PN_W'(1);
    end

    assign expired  = pend[MAX_DLY-1] & ~b;
    assign imm_fail = en & ~a & (IMPLY == 0);
    assign any_fail = expired | imm_fail;
    assign fn_nxt   = {1'b0, expired} + {1'b0, imm_fail};
    // the expired attempt is always older than a same-edge immediate fail
    assign fs_nxt   = expired ? ts - TS_W'(MAX_DLY) : ts;
    assign psum     = SW'(pass_cnt) + SW'(pn_nxt);
    assign fsum     = SW'(fail_cnt) + SW'(fn_nxt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts            <= '0;
            pend          <= '0;
            pass_o        <= 1'b0;
            pass_num      <= '0;
            fail_o        <= 1'b0;
            fail_num      <= '0;
            fail_start_ts <= '0;
            fail_end_ts   <= '0;
            pass_cnt      <= '0;
            fail_cnt      <= '0;
        end else begin
            ts            <= ts + TS_W'(1);
            pend          <= pend_nxt;
            pass_o        <= |pn_nxt;
            pass_num      <= pn_nxt;
            fail_o        <= any_fail;
            fail_num      <= fn_nxt;
            fail_start_ts <= any_fail ? fs_nxt : '0;
            fail_end_ts   <= any_fail ? ts : '0;
            pass_cnt      <= (psum > CNT_MAX) ? CNT_MAX[CNT_W-1:0]
                                              : psum[CNT_W-1:0];
            fail_cnt      <= (fsum > CNT_MAX) ? CNT_MAX[CNT_W-1:0]
                                              : fsum[CNT_W-1:0];
        end
    end

`ifdef SEQ_CHK_FIRST_FAIL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_vld      <= 1'b0;
            ff_start_ts <= '0;
            ff_end_ts   <= '0;
        end else if (any_fail && (clr || !ff_vld)) begin
            ff_vld      <= 1'b1;
            ff_start_ts <= fs_nxt;
            ff_end_ts   <= ts;
        end else if (clr) begin
            ff_vld      <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_seq_delay_checker.sv
// tb_seq_delay_checker: three configurations driven by shared random stimulus
// and compared every edge against a history-based model of the check rules.
module tb_seq_delay_checker;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic en    = 1'b0;
    logic a     = 1'b0;
    logic b     = 1'b0;

    logic po0, fo0, po1, fo1, po2, fo2;
    logic [0:0]  pn0;
    logic [1:0]  pn1;
    logic [2:0]  pn2;
    logic [1:0]  fn0, fn1, fn2;
    logic [15:0] fs0, fe0, fs1, fe1;
    logic [3:0]  fs2, fe2;
    logic [15:0] pc0, fc0, pc1, fc1;
    logic [1:0]  pc2, fc2;

`ifdef SEQ_CHK_FIRST_FAIL_EN
    logic        clr = 1'b0;
    logic        ffv0, ffv1, ffv2;
    logic [15:0] ffs0, ffe0, ffs1, ffe1;
    logic [3:0]  ffs2, ffe2;
`endif

    always #5 clk = ~clk;

    seq_delay_checker #(.MIN_DLY(2), .MAX_DLY(2), .IMPLY(0)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b),
`ifdef SEQ_CHK_FIRST_FAIL_EN
        .clr(clr), .ff_vld(ffv0), .ff_start_ts(ffs0), .ff_end_ts(ffe0),
`endif
        .pass_o(po0), .pass_num(pn0), .fail_o(fo0), .fail_num(fn0),
        .fail_start_ts(fs0), .fail_end_ts(fe0),
        .pass_cnt(pc0), .fail_cnt(fc0)
    );

    seq_delay_checker #(.MIN_DLY(1), .MAX_DLY(3), .IMPLY(1)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b),
`ifdef SEQ_CHK_FIRST_FAIL_EN
        .clr(clr), .ff_vld(ffv1), .ff_start_ts(ffs1), .ff_end_ts(ffe1),
`endif
        .pass_o(po1), .pass_num(pn1), .fail_o(fo1), .fail_num(fn1),
        .fail_start_ts(fs1), .fail_end_ts(fe1),
        .pass_cnt(pc1), .fail_cnt(fc1)
    );

    seq_delay_checker #(.MIN_DLY(1), .MAX_DLY(4), .IMPLY(0),
                        .CNT_W(2), .TS_W(4)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b),
`ifdef SEQ_CHK_FIRST_FAIL_EN
        .clr(clr), .ff_vld(ffv2), .ff_start_ts(ffs2), .ff_end_ts(ffe2),
`endif
        .pass_o(po2), .pass_num(pn2), .fail_o(fo2), .fail_num(fn2),
        .fail_start_ts(fs2), .fail_end_ts(fe2),
        .pass_cnt(pc2), .fail_cnt(fc2)
    );

    int checks = 0;
    int fails  = 0;
    int n      = 0;

    int     MN[3]   = '{2, 1, 1};
    int     MX[3]   = '{2, 3, 4};
    int     IM[3]   = '{0, 1, 0};
    longint CMAX[3] = '{65535, 65535, 3};
    int     TSM[3]  = '{65535, 65535, 15};

    bit     en_h[4096];
    bit     a_h[4096];
    bit     b_h[4096];
    longint pcm[3];
    longint fcm[3];
    bit     ffv_m[3];
    int     ffs_m[3];
    int     ffe_m[3];

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d @%0t", name, got, exp, $time);
        end
    endtask

    // Outcome of edge e from the recorded en/a/b history: each start s
    // either fails at once, passes at its first b in the window, or expires.
    function automatic void evalm(input int i, input int e, output int pn,
                                  output int fn, output int fs, output int fe);
        pn = 0; fn = 0; fs = 0; fe = 0;
        for (int s = e - MX[i]; s <= e; s++) begin
            if (s < 0 || !en_h[s & 4095]) continue;
            if (!a_h[s & 4095]) begin
                if (IM[i] == 0 && s == e) begin
                    if (fn == 0) begin fs = s; fe = e; end
                    fn++;
                end
            end else begin
                int k = -1;
                for (int t = s + MN[i]; t <= s + MX[i] && t <= e; t++)
                    if (b_h[t & 4095]) begin k = t; break; end
                if (k == e) pn++;
                else if (k < 0 && s + MX[i] == e) begin
                    if (fn == 0) begin fs = s; fe = e; end
                    fn++;
                end
            end
        end
    endfunction

    function automatic void getd(input int i,
        output logic [63:0] po, output logic [63:0] pn,
        output logic [63:0] fo, output logic [63:0] fn,
        output logic [63:0] fs, output logic [63:0] fe,
        output logic [63:0] pc, output logic [63:0] fc);
        case (i)
            0: begin po = 64'(po0); pn = 64'(pn0); fo = 64'(fo0); fn = 64'(fn0);
                     fs = 64'(fs0); fe = 64'(fe0); pc = 64'(pc0); fc = 64'(fc0); end
            1: begin po = 64'(po1); pn = 64'(pn1); fo = 64'(fo1); fn = 64'(fn1);
                     fs = 64'(fs1); fe = 64'(fe1); pc = 64'(pc1); fc = 64'(fc1); end
            default: begin po = 64'(po2); pn = 64'(pn2); fo = 64'(fo2); fn = 64'(fn2);
                     fs = 64'(fs2); fe = 64'(fe2); pc = 64'(pc2); fc = 64'(fc2); end
        endcase
    endfunction

`ifdef SEQ_CHK_FIRST_FAIL_EN
    function automatic void getff(input int i, output logic [63:0] v,
                                  output logic [63:0] s, output logic [63:0] e);
        case (i)
            0:       begin v = 64'(ffv0); s = 64'(ffs0); e = 64'(ffe0); end
            1:       begin v = 64'(ffv1); s = 64'(ffs1); e = 64'(ffe1); end
            default: begin v = 64'(ffv2); s = 64'(ffs2); e = 64'(ffe2); end
        endcase
    endfunction
`endif

    task automatic chk_zero(string tag);
        logic [63:0] po, pn, fo, fn, fs, fe, pc, fc;
        for (int i = 0; i < 3; i++) begin
            getd(i, po, pn, fo, fn, fs, fe, pc, fc);
            chk($sformatf("%s u%0d pass_o", tag, i), po, 0);
            chk($sformatf("%s u%0d fail_o", tag, i), fo, 0);
            chk($sformatf("%s u%0d pass_num", tag, i), pn, 0);
            chk($sformatf("%s u%0d fail_num", tag, i), fn, 0);
            chk($sformatf("%s u%0d pass_cnt", tag, i), pc, 0);
            chk($sformatf("%s u%0d fail_cnt", tag, i), fc, 0);
`ifdef SEQ_CHK_FIRST_FAIL_EN
            getff(i, po, fs, fe);
            chk($sformatf("%s u%0d ff_vld", tag, i), po, 0);
`endif
        end
    endtask

    task automatic compare();
        int pn, fn, fs, fe;
        logic [63:0] gpo, gpn, gfo, gfn, gfs, gfe, gpc, gfc;
        bit c;
        c = 1'b0;
        if (!rst_n) begin
            #1;
            chk_zero("held_reset");
            return;
        end
        en_h[n & 4095] = en;
        a_h[n & 4095]  = a;
        b_h[n & 4095]  = b;
`ifdef SEQ_CHK_FIRST_FAIL_EN
        c = clr;
`endif
        #1;
        for (int i = 0; i < 3; i++) begin
            evalm(i, n, pn, fn, fs, fe);
            pcm[i] = (pcm[i] + pn > CMAX[i]) ? CMAX[i] : pcm[i] + pn;
            fcm[i] = (fcm[i] + fn > CMAX[i]) ? CMAX[i] : fcm[i] + fn;
            getd(i, gpo, gpn, gfo, gfn, gfs, gfe, gpc, gfc);
            chk($sformatf("u%0d e%0d pass_o", i, n), gpo, 64'(pn > 0));
            chk($sformatf("u%0d e%0d pass_num", i, n), gpn, 64'(pn));
            chk($sformatf("u%0d e%0d fail_o", i, n), gfo, 64'(fn > 0));
            chk($sformatf("u%0d e%0d fail_num", i, n), gfn, 64'(fn));
            chk($sformatf("u%0d e%0d pass_cnt", i, n), gpc, 64'(pcm[i]));
            chk($sformatf("u%0d e%0d fail_cnt", i, n), gfc, 64'(fcm[i]));
            if (fn > 0) begin
                chk($sformatf("u%0d e%0d fail_start", i, n), gfs, 64'(fs & TSM[i]));
                chk($sformatf("u%0d e%0d fail_end", i, n), gfe, 64'(fe & TSM[i]));
            end
`ifdef SEQ_CHK_FIRST_FAIL_EN
            if (fn > 0 && (c || !ffv_m[i])) begin
                ffv_m[i] = 1'b1; ffs_m[i] = fs; ffe_m[i] = fe;
            end else if (c) begin
                ffv_m[i] = 1'b0;
            end
            getff(i, gpo, gfs, gfe);
            chk($sformatf("u%0d e%0d ff_vld", i, n), gpo, 64'(ffv_m[i]));
            if (ffv_m[i]) begin
                chk($sformatf("u%0d e%0d ff_start", i, n), gfs, 64'(ffs_m[i] & TSM[i]));
                chk($sformatf("u%0d e%0d ff_end", i, n), gfe, 64'(ffe_m[i] & TSM[i]));
            end
`endif
        end
        n++;
    endtask

    always @(posedge clk) compare();

    always @(negedge rst_n) begin
        n = 0;
        for (int i = 0; i < 3; i++) begin
            pcm[i] = 0; fcm[i] = 0; ffv_m[i] = 1'b0;
        end
        #1;
        chk_zero("reset_assert");
    end

    task automatic cyc(bit e_, bit a_, bit b_);
        @(negedge clk);
        en = e_; a = a_; b = b_;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b0; a = 1'b0; b = 1'b0;
`ifdef SEQ_CHK_FIRST_FAIL_EN
        clr = 1'b0;
`endif
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;

        // fixed window 2: immediate fail, then pass and fail on one edge
        do_reset();
        cyc(1, 1, 0);
        cyc(1, 0, 0);
        chk("A e1 fail_num", fn0, 1);
        chk("A e1 fail_start", fs0, 1);
        chk("A e1 fail_end", fe0, 1);
        cyc(1, 0, 1);
        chk("A e2 pass_num", pn0, 1);
        chk("A e2 fail_num", fn0, 1);
        chk("A e2 fail_start", fs0, 2);
        chk("A e2 fail_end", fe0, 2);

        // implication, window 1..3: pass at e3, fail 5..8
        do_reset();
        cyc(1, 1, 0);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        cyc(1, 0, 1);
        chk("B e3 pass_num", pn1, 1);
        cyc(1, 0, 0);
        cyc(1, 1, 0);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        chk("B e8 fail_o", fo1, 1);
        chk("B e8 fail_start", fs1, 5);
        chk("B e8 fail_end", fe1, 8);

        // one b passes three overlapping attempts
        do_reset();
        cyc(1, 1, 0);
        cyc(1, 1, 0);
        cyc(1, 1, 0);
        cyc(1, 0, 1);
        chk("C e3 pass_num", pn1, 3);
        chk("C e3 pass_cnt", pc1, 3);

        // attempts in flight at reset vanish, ts restarts
        do_reset();
        cyc(1, 1, 0);
        cyc(1, 0, 0);
        @(negedge clk);
        rst_n = 1'b0; en = 1'b0; a = 1'b0; b = 1'b1;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #2;
        for (int k = 0; k < 4; k++) begin
            chk("D no pass u0", po0, 0);
            chk("D no fail u0", fo0, 0);
            chk("D no pass u1", po1, 0);
            chk("D fail_cnt u0", fc0, 0);
            if (k < 3) cyc(0, 0, 1);
        end
        cyc(1, 0, 0);
        chk("D e4 fail_start", fs0, 4);
        chk("D e4 fail_end", fe0, 4);

        // counter saturation at CNT_W=2
        do_reset();
        for (int k = 0; k < 5; k++) cyc(1, 0, 0);
        chk("E fail_cnt sat", fc2, 3);
        chk("E fail_cnt wide", fc0, 5);

`ifdef SEQ_CHK_FIRST_FAIL_EN
        // first-fail capture holds until clr
        do_reset();
        for (int k = 0; k < 4; k++) cyc(0, 0, 0);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        chk("F e7 ff_vld", ffv0, 1);
        chk("F e7 ff_start", ffs0, 4);
        clr = 1'b1;
        cyc(0, 0, 0);
        chk("F e8 ff_vld", ffv0, 0);
        clr = 1'b0;
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        chk("F e10 ff_start", ffs0, 10);
        clr = 1'b1;
        cyc(1, 0, 0);
        chk("F e11 ff_start", ffs0, 11);
        clr = 1'b0;
`endif

        do_reset();
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 299) == 0) begin
                @(negedge clk);
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end else begin
                @(negedge clk);
                en = ($urandom % 4) != 0;
                a  = ($urandom % 2) != 0;
                b  = ($urandom % 10) < 3;
`ifdef SEQ_CHK_FIRST_FAIL_EN
                clr = ($urandom % 16) == 0;
`endif
            end
        end
        @(posedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
